// File: rtl/buffer_capture_sequencer_pkg.sv
// Shared types and constants for the sample-buffer capture sequencer.
// State codes double as the RGB LED decoder encoding.
package pkg_global;

    localparam int unsigned ADDR_W = 4;

    typedef logic [ADDR_W-1:0] bits_n;

    localparam logic [2:0] LED_IDLE       = 3'd0;
    localparam logic [2:0] LED_CAPT_WAIT  = 3'd1;
    localparam logic [2:0] LED_CAPT_WR    = 3'd2;
    localparam logic [2:0] LED_DRAIN_IDLE = 3'd3;
    localparam logic [2:0] LED_DRAIN_RD   = 3'd4;
    localparam logic [2:0] LED_DRAIN_OUT  = 3'd5;
    localparam logic [2:0] LED_ERR        = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE       = LED_IDLE,
        S_CAPT_WAIT  = LED_CAPT_WAIT,
        S_CAPT_WR    = LED_CAPT_WR,
        S_DRAIN_IDLE = LED_DRAIN_IDLE,
        S_DRAIN_RD   = LED_DRAIN_RD,
        S_DRAIN_OUT  = LED_DRAIN_OUT,
        S_ERR        = LED_ERR
    } seq_state_t;

endpackage

// File: rtl/buffer_capture_sequencer_timeout.sv
// Sensor-wait timeout counter: counts while enabled, flags the terminal count
// (TIMEOUT_CYC-1) and holds there until cleared.
module seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/buffer_capture_sequencer.sv
// Capture N sensor samples into the sample buffer, then drain them one byte
// per SD-writer request; optional continuous restart after each drain.
module buffer_capture_sequencer
    import pkg_global::*;
#(
    parameter int unsigned N_SAMPLES   = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        modo_i,
    input  logic        start_i,
    input  logic        sensor_valid_i,
    input  logic [7:0]  sensor_data_i,
    input  logic [7:0]  buf_rdata_i,
    output logic        en_sensor_o,
    output bits_n       buf_addr_o,
    output logic        buf_we_o,
    output logic [7:0]  buf_wdata_o,
    input  logic        rd_req_i,
    output logic        rd_valid_o,
    output logic [7:0]  rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    localparam bits_n LAST_IDX = bits_n'(N_SAMPLES - 1);

    seq_state_t state;
    seq_state_t next_state;

    logic       last_idx;
    logic       tmo_clear;
    logic       tmo_en;
    logic       tmo_tc;

    bits_n      addr_d;
    logic [7:0] wdata_d;
    logic       we_d;
    logic       en_sensor_d;
    logic       rd_valid_d;
    logic [7:0] rd_data_d;
    logic       busy_d;
    logic       done_d;
    logic       err_d;

    assign last_idx  = (buf_addr_o == LAST_IDX);
    assign tmo_en    = (state == S_CAPT_WAIT);
    assign tmo_clear = (state != S_CAPT_WAIT);

    seq_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clear (tmo_clear),
        .enable(tmo_en),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A sample arriving on the terminal-count cycle still wins over the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:       if (start_i) next_state = S_CAPT_WAIT;
            S_CAPT_WAIT: begin
                if (sensor_valid_i) begin
                    next_state = S_CAPT_WR;
                end else if (tmo_tc) begin
                    next_state = S_ERR;
                end
            end
            S_CAPT_WR:    next_state = last_idx ? S_DRAIN_IDLE : S_CAPT_WAIT;
            S_DRAIN_IDLE: if (rd_req_i) next_state = S_DRAIN_RD;
            S_DRAIN_RD:   next_state = S_DRAIN_OUT;
            S_DRAIN_OUT: begin
                if (!last_idx) begin
                    next_state = S_DRAIN_IDLE;
                end else if (modo_i) begin
                    next_state = S_CAPT_WAIT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_ERR:        if (start_i) next_state = S_CAPT_WAIT;
            default:      next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they belong to; the buffer address is stable through the whole read.
    always_comb begin
        addr_d = buf_addr_o;
        unique case (state)
            S_IDLE, S_ERR:          if (start_i) addr_d = '0;
            S_CAPT_WR, S_DRAIN_OUT: addr_d = last_idx ? '0 : buf_addr_o + bits_n'(1);
            default:                addr_d = buf_addr_o;
        endcase

        wdata_d = buf_wdata_o;
        if (state == S_CAPT_WAIT && sensor_valid_i) begin
            wdata_d = sensor_data_i;
        end

        rd_data_d = rd_data_o;
        if (next_state == S_DRAIN_OUT) begin
            rd_data_d = buf_rdata_i;
        end

        we_d        = (next_state == S_CAPT_WR);
        en_sensor_d = (next_state == S_CAPT_WAIT) || (next_state == S_CAPT_WR);
        rd_valid_d  = (next_state == S_DRAIN_OUT);
        done_d      = (next_state == S_DRAIN_OUT) && last_idx;
        busy_d      = (next_state != S_IDLE);
        err_d       = (next_state == S_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_addr_o  <= '0;
            buf_wdata_o <= '0;
            buf_we_o    <= 1'b0;
            en_sensor_o <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            buf_addr_o  <= addr_d;
            buf_wdata_o <= wdata_d;
            buf_we_o    <= we_d;
            en_sensor_o <= en_sensor_d;
            rd_valid_o  <= rd_valid_d;
            rd_data_o   <= rd_data_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_buffer_capture_sequencer.sv
// Randomized bench for buffer_capture_sequencer with a transaction-level
// reference model (expected-sample queue) and a behavioural sample buffer.
module tb_buffer_capture_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 8;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_WAIT  = 3'd1;
    localparam logic [2:0] C_WR    = 3'd2;
    localparam logic [2:0] C_DIDLE = 3'd3;
    localparam logic [2:0] C_ERR   = 3'd7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               modo;
    logic               start;
    logic               svalid;
    logic [7:0]         sdata;
    logic [7:0]         buf_rdata;
    logic               en_sensor;
    pkg_global::bits_n  addr;
    logic               we;
    logic [7:0]         wdata;
    logic               rd_req;
    logic               rd_valid;
    logic [7:0]         rd_data;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         state;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] mem [0:(1 << pkg_global::ADDR_W) - 1];
    logic [7:0] expq[$];

    buffer_capture_sequencer #(
        .N_SAMPLES  (N),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .modo_i        (modo),
        .start_i       (start),
        .sensor_valid_i(svalid),
        .sensor_data_i (sdata),
        .buf_rdata_i   (buf_rdata),
        .en_sensor_o   (en_sensor),
        .buf_addr_o    (addr),
        .buf_we_o      (we),
        .buf_wdata_o   (wdata),
        .rd_req_i      (rd_req),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    // Sample buffer with one-cycle synchronous read.
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        buf_rdata <= mem[addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_state"}, state, 0);
        check({pfx, "_en"}, en_sensor, 0);
        check({pfx, "_addr"}, addr, 0);
        check({pfx, "_we"}, we, 0);
        check({pfx, "_wdata"}, wdata, 0);
        check({pfx, "_rvalid"}, rd_valid, 0);
        check({pfx, "_rdata"}, rd_data, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
    endtask

    task automatic start_capture();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expq.delete();
        check("start_state", state, C_WAIT);
        check("start_en", en_sensor, 1);
        check("start_addr", addr, 0);
        check("start_busy", busy, 1);
        check("start_err", err, 0);
    endtask

    // Waits `gap` cycles with spurious start/rd_req, then delivers one sample.
    task automatic capture_sample(input int unsigned idx, input int unsigned gap, input logic [7:0] d);
        for (int unsigned k = 0; k < gap; k++) begin
            start  = 1'($urandom_range(0, 1));
            rd_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            start  = 1'b0;
            rd_req = 1'b0;
            check("wait_state", state, C_WAIT);
            check("wait_en", en_sensor, 1);
            check("wait_we", we, 0);
            check("wait_rvalid", rd_valid, 0);
        end
        svalid = 1'b1;
        sdata  = d;
        @(negedge clk);
        svalid = 1'b0;
        expq.push_back(d);
        check("wr_we", we, 1);
        check("wr_addr", addr, idx);
        check("wr_data", wdata, d);
        check("wr_state", state, C_WR);
        @(negedge clk);
        check("post_wr_we", we, 0);
        check("post_wr_busy", busy, 1);
        if (idx < N - 1) begin
            check("post_wr_state", state, C_WAIT);
            check("post_wr_en", en_sensor, 1);
            check("post_wr_addr", addr, idx + 1);
        end else begin
            check("cap_end_state", state, C_DIDLE);
            check("cap_end_en", en_sensor, 0);
            check("cap_end_addr", addr, 0);
        end
    endtask

    task automatic random_pass();
        for (int unsigned i = 0; i < N; i++) begin
            capture_sample(i, $urandom_range(0, TMO - 1), 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic drain(input bit hold, input bit exp_restart);
        int unsigned got_n = 0;
        int unsigned cyc = 0;
        int unsigned last_cyc = 0;
        logic [7:0] e;
        while (got_n < N && cyc < 200) begin
            rd_req = hold ? 1'b1 : 1'($urandom_range(0, 1));
            svalid = 1'($urandom_range(0, 1));
            sdata  = 8'($urandom_range(0, 255));
            @(negedge clk);
            cyc++;
            svalid = 1'b0;
            check("drain_we", we, 0);
            if (rd_valid) begin
                e = expq.pop_front();
                check("drain_data", rd_data, e);
                check("drain_done", done, (got_n == N - 1) ? 1 : 0);
                if (hold && got_n > 0) check("drain_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                got_n++;
            end else begin
                check("drain_nodone", done, 0);
            end
        end
        rd_req = 1'b0;
        check("drain_count", got_n, N);
        @(negedge clk);
        check("after_drain_done", done, 0);
        check("after_drain_rvalid", rd_valid, 0);
        check("after_drain_addr", addr, 0);
        if (exp_restart) begin
            check("restart_state", state, C_WAIT);
            check("restart_en", en_sensor, 1);
            check("restart_busy", busy, 1);
            expq.delete();
        end else begin
            check("idle_state", state, C_IDLE);
            check("idle_busy", busy, 0);
            check("idle_en", en_sensor, 0);
        end
    endtask

    initial begin
        int unsigned cnt;
        logic [7:0] fixed_data [0:3];
        int unsigned fixed_gap [0:3];
        fixed_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        fixed_gap  = '{0, 1, TMO - 1, 2};

        rst_n = 1'b0; modo = 1'b0; start = 1'b0; svalid = 1'b0;
        sdata = '0; rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_state", state, C_IDLE);

        // Spurious sample and read request in IDLE.
        svalid = 1'b1; sdata = 8'hA5; rd_req = 1'b1;
        @(negedge clk);
        svalid = 1'b0; rd_req = 1'b0;
        check("idle_sv_state", state, C_IDLE);
        check("idle_sv_we", we, 0);
        check("idle_sv_rvalid", rd_valid, 0);

        // Single capture with known data; one sample on the last allowed cycle.
        start_capture();
        for (int unsigned i = 0; i < N; i++) capture_sample(i, fixed_gap[i], fixed_data[i]);
        drain(1'b1, 1'b0);

        // Continuous mode: second pass begins without start; mode drops mid-capture.
        modo = 1'b1;
        start_capture();
        random_pass();
        drain(1'b0, 1'b1);
        capture_sample(0, 1, 8'($urandom_range(0, 255)));
        modo = 1'b0;
        for (int unsigned i = 1; i < N; i++) capture_sample(i, $urandom_range(0, 3), 8'($urandom_range(0, 255)));
        drain(1'b1, 1'b0);

        // Timeout into ERR, sticky flag, restart.
        start_capture();
        cnt = 1;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state != C_WAIT) break;
            cnt++;
        end
        check("tmo_cycles", cnt, TMO);
        check("tmo_state", state, C_ERR);
        check("tmo_err", err, 1);
        check("tmo_en", en_sensor, 0);
        check("tmo_we", we, 0);
        repeat (3) begin
            svalid = 1'b1; rd_req = 1'b1;
            @(negedge clk);
            svalid = 1'b0; rd_req = 1'b0;
            check("err_sticky", err, 1);
            check("err_hold_state", state, C_ERR);
        end
        start_capture();
        random_pass();
        drain(1'b0, 1'b0);

        // Asynchronous reset while writing sample 2.
        start_capture();
        capture_sample(0, $urandom_range(0, 3), 8'($urandom_range(0, 255)));
        capture_sample(1, $urandom_range(0, 3), 8'($urandom_range(0, 255)));
        svalid = 1'b1; sdata = 8'h5A;
        @(negedge clk);
        svalid = 1'b0;
        check("mid_wr_we", we, 1);
        check("mid_wr_addr", addr, 2);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", state, C_IDLE);
        check("post_rst_we", we, 0);
        start_capture();
        random_pass();
        drain(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
